// File: rtl/simac_pkg.sv
// rtl/simac_pkg.sv - shared opcodes, fetch states and widths for the accumulator CPU
package simac_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_JC  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;

    // jmp qualifies the branch; the flags select which conditional branch fires
    function automatic logic branch_taken(
        input logic [2:0] op,
        input logic       jmp,
        input logic       zf,
        input logic       cf
    );
        return jmp && ((op == OP_JMP) || ((op == OP_JZ) && zf) || ((op == OP_JC) && cf));
    endfunction

endpackage

// File: rtl/fetch_unit_pc_unit.sv
// rtl/fetch_unit_pc_unit.sv - program counter register with load-over-increment priority
module pc_unit
    import simac_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_en,
    input  logic          load_en,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else if (load_en) begin
            pc_q <= load_val;
        end else if (inc_en) begin
            pc_q <= pc_q + AW'(1);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch/decode/execute sequencer owning the PC and instruction register
module fetch_unit
    import simac_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic [2:0]    op_o,
    output logic [AW-1:0] operand_o,
    output logic          exec_o,
    input  logic          exec_done_i,
    input  logic          jmp_i,
    input  logic          zf_i,
    input  logic          cf_i,
    output logic [AW-1:0] pc_o,
    output logic          halted_o
);

    fetch_state_t  state;
    logic [DW-1:0] ir;
    logic          mem_rd_q;
    logic          exec_q;
    logic          halted_q;
    logic [AW-1:0] pc;
    logic          exec_fire;
    logic          taken;

    assign op_o      = ir[DW-1:DW-3];
    assign operand_o = ir[AW-1:0];

    // PC only moves on the edge that retires an instruction
    assign exec_fire = (state == ST_EXEC) && exec_done_i;
    assign taken     = branch_taken(op_o, jmp_i, zf_i, cf_i);

    pc_unit #(.AW(AW)) u_pc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_en   (exec_fire && !taken),
        .load_en  (exec_fire && taken),
        .load_val (operand_o),
        .pc       (pc)
    );

    // Moore outputs are registered alongside the state they decode
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            ir       <= '0;
            mem_rd_q <= 1'b0;
            exec_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    mem_rd_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (mem_ack_i) begin
                        ir       <= mem_rdata_i;
                        state    <= ST_DECODE;
                        mem_rd_q <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (op_o == OP_HLT) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state  <= ST_EXEC;
                        exec_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (exec_done_i) begin
                        state    <= ST_FETCH;
                        exec_q   <= 1'b0;
                        mem_rd_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_rd_q <= 1'b0;
                    exec_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign exec_o     = exec_q;
    assign halted_o   = halted_q;
    assign pc_o       = pc;
    assign mem_addr_o = pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage for the accumulator CPU, directly upstream of `ctrlunit`. It owns the program counter and instruction register, and runs a fetch/decode/execute state machine against a handshaked instruction memory. It presents the latched 3-bit opcode to the control unit and the 5-bit operand address to the datapath. It resolves JMP/JZ/JC using the control unit's jump indication and the ALU flags, and stops permanently on HLT.

## Interface
- `AW`, default 5: address width; also the PC width and the operand field width.
- `DW`, default 8: instruction word width. Opcode is `[DW-1:DW-3]`; operand is `[AW-1:0]`.
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mem_addr_o`  out  AW  instruction fetch address; equals `pc_o` while `mem_rd_o`=1.
- `mem_rd_o`  out  1  fetch request; held until acknowledged.
- `mem_rdata_i`  in  DW  instruction word; valid when `mem_ack_i`=1.
- `mem_ack_i`  in  1  fetch complete; sampled only in FETCH.
- `op_o`  out  3  registered opcode; feeds `ctrlunit.op_i`.
- `operand_o`  out  AW  registered operand address.
- `exec_o`  out  1  execute strobe (level) to the datapath.
- `exec_done_i`  in  1  datapath finished the current instruction; sampled only in EXEC.
- `jmp_i`  in  1  jump-class indication from the control unit.
- `zf_i`, `cf_i`  in  1 each  zero and carry flags from the ALU, sampled in EXEC.
- `pc_o`  out  AW  current program counter.
- `halted_o`  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. Outputs are Moore-decoded: `mem_rd_o`=(FETCH), `exec_o`=(EXEC), `halted_o`=(HALT).
- IDLE → FETCH unconditionally after one cycle.
- FETCH: wait for `mem_ack_i`. On ack, latch `mem_rdata_i` into the IR, then → DECODE. With no ack, stay in FETCH with the request held.
- DECODE: one settle cycle for `ctrlunit`. If op=3'b111 (HLT) → HALT; else → EXEC.
- EXEC: wait for `exec_done_i`. On done, update the PC, then → FETCH.
  - Taken = `jmp_i` & (op=100 | (op=101 & `zf_i`) | (op=110 & `cf_i`)).
  - If taken: PC ← `operand_o`; else PC ← PC+1.
- PC increment is modulo 2^AW: 5'h1F+1 → 5'h00, with no flag.
- HALT is absorbing; only `rst_i` leaves it. PC and IR are frozen in HALT.
- `op_o` and `operand_o` come straight from the IR. They change only on the FETCH ack edge and stay stable through DECODE and EXEC.
- `mem_ack_i` outside FETCH and `exec_done_i` outside EXEC are ignored.

## Timing
- Reset values: state=IDLE, PC=0, IR=0. Therefore `op_o`=0, `operand_o`=0, `mem_rd_o`=0, `exec_o`=0, `halted_o`=0, `mem_addr_o`=0, `pc_o`=0.
- Reset mid-operation (any state, including HALT): all of the above take effect on the next clock edge. A pending fetch or execute is abandoned and no PC update occurs.
- First `mem_rd_o` is asserted in the 2nd cycle after `rst_i` deasserts.
- Minimum instruction time is 3 cycles (FETCH, DECODE, EXEC), with ack and done each arriving in the first cycle of their state.
- `exec_done_i` may be asserted in the first EXEC cycle.
- The new PC is visible on `pc_o` and `mem_addr_o` in the first FETCH cycle after EXEC.
- Flags are sampled on the same edge as `exec_done_i`.

## Structure
- Shared package `simac_pkg` holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_LDA=010, OP_STA=011, OP_JMP=100, OP_JZ=101, OP_JC=110, OP_HLT=111;
  - the fetch state enum;
  - the AW/DW defaults.
- `ctrlunit` should adopt the same opcode constants.
- One sub-module, `pc_unit`: the PC register with synchronous reset, increment enable, and load enable plus load value. Load has priority over increment.

## Test plan
- Reset, then memory acks immediately and `exec_done_i` is tied high; program {0x00, 0x20, 0xE0}:
  - `pc_o` steps 0 → 1 → 2 at 3-cycle intervals.
  - `op_o` takes the values 000, 001, 111.
  - `halted_o`=1 from cycle 10 onward and `mem_rd_o` stays 0.
- Fetch stall: `mem_ack_i` is delayed 4 cycles. `mem_rd_o` and `mem_addr_o` are held for 5 cycles, and the IR is unchanged until the ack edge.
- Branches:
  - JZ 0x0A (0xAA) with `jmp_i`=1: if `zf_i`=1 the next fetch address is 0x0A; if `zf_i`=0 it is PC+1.
  - JC (0xC5) with `cf_i`=1: the next fetch address is 0x05.
- Wrap: JMP 0x1F (0x9F), then ADD at 0x1F. The fetch after the ADD is at 0x00.
- Mid-execute reset: `rst_i` is pulsed during EXEC with `exec_done_i`=0. The next cycle has state IDLE, PC=0, and `exec_o`=0; the following cycle has a fetch at 0x00.
- Spurious inputs: `exec_done_i` pulsed during FETCH and `mem_ack_i` pulsed during EXEC have no effect on the state or the PC.
